// File: rtl/fifo_buffer_if.sv
// Producer/consumer handshake bundle for fifo_buffer; "slave" is the FIFO's view,
// "master" is the surrounding logic that pushes into and pops from it.
interface fifo_buffer_if #(
  parameter int Nb = 48,
  parameter int M  = 2
);
  logic          in_valid;
  logic          in_ready;
  logic [Nb-1:0] in_data;
  logic [M:0]    in_count;
  logic          out_valid;
  logic          out_ready;
  logic [Nb-1:0] out_data;
  logic [M:0]    out_count;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, in_count, out_valid, out_data, out_count
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, in_count, out_valid, out_data, out_count
  );
endinterface

// File: rtl/fifo_buffer.sv
// Single-clock FWFT FIFO, 2^M x Nb; a written word is visible right after its write edge; in_ready drops when full.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs, cleared only by reset_n.
module fifo_buffer #(
  parameter int Nb = 48,
  parameter int M  = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  fifo_buffer_if.slave fif
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic         overflow,
  output logic         underflow
`endif
);
  localparam int         Depth    = 2 ** M;
  localparam logic [M:0] DepthCnt = Depth[M:0];

  logic [M:0]    wr_ptr_q, wr_ptr_d;
  logic [M:0]    rd_ptr_q, rd_ptr_d;
  logic [M:0]    count;
  logic [Nb-1:0] mem_q [Depth];
  logic          full, empty;
  logic          wr_en, rd_en;

  // The extra pointer MSB makes the difference span 0..Depth, so full and empty are distinct.
  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == DepthCnt);
  assign empty = (count == '0);

  // reset_n gate keeps the producer stalled while reset is held.
  assign fif.in_ready  = reset_n & ~full;
  assign fif.out_valid = ~empty;
  assign fif.out_data  = mem_q[rd_ptr_q[M-1:0]];
  assign fif.in_count  = count;
  assign fif.out_count = count;

  assign wr_en = fif.in_valid & fif.in_ready;
  assign rd_en = fif.out_ready & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + {{M{1'b0}}, 1'b1};
    if (rd_en) rd_ptr_d = rd_ptr_q + {{M{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[M-1:0]] <= fif.in_data;
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q | (fif.in_valid & ~fif.in_ready);
    underflow_d = underflow_q | (fif.out_ready & empty);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif
endmodule

// File: tb/tb_fifo_buffer.sv
// Bench for fifo_buffer: directed phases plus random traffic, checked against a queue model.
module tb_fifo_buffer;
  localparam int Nb    = 48;
  localparam int M     = 2;
  localparam int Depth = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fifo_buffer_if #(.Nb(Nb), .M(M)) fif ();

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow, underflow;
  logic ovf_exp, unf_exp;
`endif

  fifo_buffer #(.Nb(Nb), .M(M)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .fif     (fif)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  logic [Nb-1:0] model_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    model_q.delete();
`ifdef FIFO_ERR_FLAGS_EN
    ovf_exp = 1'b0;
    unf_exp = 1'b0;
`endif
  endtask

  // One clock cycle: called just after a falling edge, returns just after the next one.
  task automatic step(input logic iv, input logic [Nb-1:0] id, input logic ordy, input string tag);
    bit do_wr, do_rd;
    fif.in_valid  = iv;
    fif.in_data   = id;
    fif.out_ready = ordy;
    #1;
    check({tag, ".in_ready"},  64'(fif.in_ready),  64'(model_q.size() < Depth));
    check({tag, ".out_valid"}, 64'(fif.out_valid), 64'(model_q.size() > 0));
    check({tag, ".in_count"},  64'(fif.in_count),  64'(model_q.size()));
    check({tag, ".out_count"}, 64'(fif.out_count), 64'(model_q.size()));
    if (model_q.size() > 0) check({tag, ".out_data"}, 64'(fif.out_data), 64'(model_q[0]));
`ifdef FIFO_ERR_FLAGS_EN
    check({tag, ".overflow"},  64'(overflow),  64'(ovf_exp));
    check({tag, ".underflow"}, 64'(underflow), 64'(unf_exp));
`endif
    @(posedge clk);
    do_wr = iv && (model_q.size() < Depth);
    do_rd = ordy && (model_q.size() > 0);
`ifdef FIFO_ERR_FLAGS_EN
    if (iv && model_q.size() >= Depth) ovf_exp = 1'b1;
    if (ordy && model_q.size() == 0) unf_exp = 1'b1;
`endif
    if (do_rd) void'(model_q.pop_front());
    if (do_wr) model_q.push_back(id);
    @(negedge clk);
  endtask

  task automatic check_reset_view(input string tag);
    check({tag, ".in_ready"},  64'(fif.in_ready),  64'd0);
    check({tag, ".out_valid"}, 64'(fif.out_valid), 64'd0);
    check({tag, ".in_count"},  64'(fif.in_count),  64'd0);
    check({tag, ".out_count"}, 64'(fif.out_count), 64'd0);
  endtask

  logic [Nb-1:0] fill_words [4];

  initial begin
    fill_words[0] = 48'h000001000002;
    fill_words[1] = 48'h000003000004;
    fill_words[2] = 48'h000005000006;
    fill_words[3] = 48'h000007000008;
    model_clear();

    // Reset held with a producer pushing: nothing may be accepted.
    fif.in_valid  = 1'b1;
    fif.in_data   = 48'h123456789ABC;
    fif.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_view("rst_hold");
    reset_n = 1'b1;
    fif.in_valid  = 1'b0;
    fif.out_ready = 1'b0;
    #1;
    check({"rst_rel", ".in_ready"},  64'(fif.in_ready),  64'd1);
    check({"rst_rel", ".out_valid"}, 64'(fif.out_valid), 64'd0);
    check({"rst_rel", ".count"},     64'(fif.out_count), 64'd0);
    @(negedge clk);

    // Fill to full, then an extra word that must be refused.
    for (int i = 0; i < 4; i++) step(1'b1, fill_words[i], 1'b0, "fill");
    check("full.in_ready", 64'(fif.in_ready), 64'd0);
    step(1'b1, 48'hFFFFFFFFFFFF, 1'b0, "fill_extra");
    step(1'b0, '0, 1'b0, "full_idle");

    // Drain in write order.
    for (int i = 0; i < 4; i++) begin
      #1;
      check("drain.order", 64'(fif.out_data), 64'(fill_words[i]));
      #0;
      step(1'b0, '0, 1'b1, "drain");
    end
    step(1'b0, '0, 1'b1, "drain_empty");

    // FWFT: word visible the cycle after its write edge, then read it.
    step(1'b1, 48'hABCDEF123456, 1'b0, "fwft_wr");
    check("fwft.out_valid", 64'(fif.out_valid), 64'd1);
    check("fwft.out_data",  64'(fif.out_data),  64'hABCDEF123456);
    step(1'b0, '0, 1'b1, "fwft_rd");
    step(1'b0, '0, 1'b0, "fwft_after");

    // Steady occupancy of 2 with simultaneous push/pop across pointer wraps.
    step(1'b1, 48'h0000AA000001, 1'b0, "conc_pre");
    step(1'b1, 48'h0000AA000002, 1'b0, "conc_pre");
    for (int i = 0; i < 20; i++) step(1'b1, {16'h0000, 32'($urandom)}, 1'b1, "conc");
    check("conc.count", 64'(fif.out_count), 64'd2);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(1'(($urandom_range(0, 3) != 0)), {16'($urandom), 32'($urandom)},
           1'(($urandom_range(0, 3) > 1)), "rand");

    // Drain, fill to 3, then assert reset between edges.
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, "pre_arst");
    for (int i = 0; i < 3; i++) step(1'b1, {16'h00C0, 32'(i)}, 1'b0, "pre_arst_fill");
`ifdef FIFO_ERR_FLAGS_EN
    for (int i = 0; i < 2; i++) step(1'b1, 48'hBAD0BAD0BAD0, 1'b0, "ovf_push");
    check("ovf.sticky", 64'(overflow), 64'd1);
    step(1'b0, '0, 1'b1, "ovf_hold");
`endif
    check("pre_arst.count", 64'(fif.out_count), 64'(model_q.size()));
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_view("arst");
`ifdef FIFO_ERR_FLAGS_EN
    check("arst.overflow",  64'(overflow),  64'd0);
    check("arst.underflow", 64'(underflow), 64'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    step(1'b0, '0, 1'b0, "post_arst");
    step(1'b1, 48'h5A5A5A5A5A5A, 1'b0, "post_arst_wr");
    step(1'b0, '0, 1'b1, "post_arst_rd");
    step(1'b0, '0, 1'b0, "post_arst_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_buffer.md
Name: fifo_buffer

Overview:
- Single-clock first-word-fall-through (FWFT) FIFO carrying Nb-bit words between a producer and a consumer.
- Both sides use the valid/ready handshake of FIFOInterface.
- Used as a small sample buffer in front of serializers, e.g. to hold packed 48-bit left/right audio sample pairs ahead of an I2S shifter.
- Exports occupancy counts to both sides.

Parameters:
- Nb, 48, data word width in bits.
- M, 2, log2 of depth; depth = 2^M words (default 4).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  FIFO can accept a word this cycle.
- in_data  input  Nb  write data.
- in_count  output  M+1  occupancy as seen by the producer.
- out_valid  output  1  out_data holds the head word.
- out_ready  input  1  consumer takes the head word this cycle.
- out_data  output  Nb  head word (FWFT).
- out_count  output  M+1  occupancy as seen by the consumer.

Behaviour:
- Storage: 2^M x Nb array.
- Write pointer and read pointer are each M+1 bits; the extra MSB distinguishes full from empty.
- Reset: reset_n low asynchronously clears both pointers and the count. While reset is held: in_ready=0, out_valid=0, in_count=out_count=0, out_data don't-care. Array contents are not reset.
- After reset deasserts: in_ready=1 on the first cycle.
- Write: occurs on a rising edge when in_valid && in_ready. Word is stored at wr_ptr[M-1:0]; wr_ptr increments and wraps modulo 2^(M+1).
- Read: occurs on a rising edge when out_valid && out_ready; rd_ptr increments.
- Asserting out_ready while out_valid=0 has no effect.
- in_ready = not full, where full means count == 2^M. Combinational from registered state only.
- out_valid = not empty, where empty means count == 0.
- out_data = array[rd_ptr[M-1:0]]. Combinational FWFT: the consumer samples out_data in the same cycle it sees out_valid && out_ready.
- Latency: a word written at edge k gives out_valid=1 and valid out_data from just after edge k. No pass-through while empty.
- count = wr_ptr - rd_ptr, width M+1.
- in_count and out_count are identical in this single-clock block; both are kept for interface compatibility.
- Simultaneous write and read (neither full nor empty): both happen; count unchanged.
- When full: in_ready=0, so a write in the same cycle as a read is refused even though a slot frees. Producer retries next cycle.
- When empty: a read is refused; a write still proceeds.
- Pointer wrap-around must be seamless; data order is preserved across any number of wraps.
- in_data and in_valid are ignored when in_ready=0.
- No output depends combinationally on in_valid or out_ready.
- Reset mid-operation: all stored words are discarded immediately and the FIFO presents empty.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- Defined: adds outputs overflow (1 bit) and underflow (1 bit), both sticky and cleared only by reset_n.
  - overflow sets on a rising edge with in_valid=1 and in_ready=0.
  - underflow sets on a rising edge with out_ready=1 and out_valid=0.
  - Flags never alter data flow.
- Not defined: these ports do not exist; no extra logic.

Test Plan:
- Reset: hold reset_n=0, drive in_valid=1 -> in_ready=0, out_valid=0, counts=0. Release -> in_ready=1, counts=0, no phantom word.
- Fill: write 0x000001000002, 0x000003000004, 0x000005000006, 0x000007000008 with out_ready=0 -> counts 1,2,3,4; in_ready=0 after the 4th write; a 5th word 0xFFFFFFFFFFFF is not stored.
- Drain: out_ready=1 from full -> out_data delivers the four words in write order, one per cycle; out_valid=0 and count=0 afterwards.
- FWFT latency: write 0xABCDEF123456 into an empty FIFO -> out_valid=1 and out_data=0xABCDEF123456 on the next cycle; read same cycle -> count back to 0.
- Concurrent: keep count=2, drive write and read every cycle for 20 cycles (crossing the pointer wrap) -> count stays 2, output sequence equals input sequence delayed by 2 words.
- Async reset mid-stream: with count=3, pull reset_n low between clock edges -> out_valid and counts drop immediately. With FIFO_ERR_FLAGS_EN, write while full -> overflow=1 until reset.
